// File: rtl/mux32_arb_rr_if.sv
// rtl/mux32_arb_rr_if.sv - stream bundle between NCH producers, the arbiter and the result bus
//
// Purpose: groups the input streams, channel select and registered output stream
// of mux32_arb_rr so the block and its neighbours connect through one port.
// Signals:
//   in_valid  [NCH]        per-channel data valid               (producer -> arbiter)
//   in_data   [NCH*WIDTH]  channel i at [i*WIDTH +: WIDTH]     (producer -> arbiter)
//   in_ready  [NCH]        per-channel accept, one-hot or zero  (arbiter -> producer)
//   sel       [SELW]       external channel select, MODE=0 only (producer -> arbiter)
//   out_valid              output register holds valid data     (arbiter -> sink)
//   out_data  [WIDTH]      registered winning word              (arbiter -> sink)
//   out_ch    [SELW]       channel that produced out_data       (arbiter -> sink)
//   out_ready              downstream accept                    (sink -> arbiter)
// Modports: slave = arbiter view, master = producer/sink view.

interface mux32_arb_rr_if #(
    parameter int WIDTH = 32,
    parameter int NCH   = 3
);
    localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0]       in_valid;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_ready;
    logic [SELW-1:0]      sel;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_ch;
    logic                 out_ready;

    modport slave (
        input  in_valid,
        input  in_data,
        input  sel,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_ch
    );

    modport master (
        output in_valid,
        output in_data,
        output sel,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_ch
    );
endinterface

// File: rtl/mux32_arb_rr.sv
// rtl/mux32_arb_rr.sv - NCH-to-1 valid/ready stream merger with one output register stage
//
// Purpose: picks one of NCH input streams each cycle, either by the external sel
// input (MODE=0) or round-robin over the valid inputs (MODE=1), and registers the
// winning word onto the shared result stream together with its channel index.
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of mux32_arb_rr_if (in_valid/in_data/in_ready/sel,
//          out_valid/out_data/out_ch/out_ready)
// Parameters: WIDTH data width, NCH channel count (2..16), MODE 0=sel, 1=round-robin.

module mux32_arb_rr #(
    parameter int WIDTH = 32,
    parameter int NCH   = 3,
    parameter int MODE  = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    mux32_arb_rr_if.slave bus
);
    localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1;
    // One extra bit so NCH itself and ptr+k (< 2*NCH) are representable.
    localparam logic [SELW:0]   NCH_W   = (SELW + 1)'(NCH);
    localparam logic [SELW-1:0] LAST_CH = SELW'(NCH - 1);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [SELW-1:0]  r_out_ch;
    logic [SELW-1:0]  r_ptr;

    logic             w_load;
    logic             w_rr_found;
    logic [SELW-1:0]  w_rr_grant;
    logic [SELW:0]    w_rr_idx;
    logic             w_grant_ok;
    logic [SELW-1:0]  w_grant;
    logic             w_grant_valid;
    logic [NCH-1:0]   w_ready;
    logic [WIDTH-1:0] w_data;
    logic             w_xfer;

    // The output register can take a new word when it is empty or being drained.
    assign w_load = !r_out_valid || bus.out_ready;

    // Round-robin search starting at r_ptr and wrapping past NCH-1 to 0.
    // The inner loop maps the computed index onto a constant channel number so
    // in_valid is never indexed beyond NCH-1.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_grant = '0;
        w_rr_idx   = '0;
        for (int k = 0; k < NCH; k++) begin
            w_rr_idx = {1'b0, r_ptr} + (SELW + 1)'(k);
            if (w_rr_idx >= NCH_W) begin
                w_rr_idx = w_rr_idx - NCH_W;
            end
            for (int i = 0; i < NCH; i++) begin
                if (!w_rr_found && (w_rr_idx == (SELW + 1)'(i)) && bus.in_valid[i]) begin
                    w_rr_found = 1'b1;
                    w_rr_grant = SELW'(i);
                end
            end
        end
    end

    // Grant source. In MODE=0 an out-of-range sel means no grant at all, so the
    // output stream simply drains as if no producer were offering data.
    always_comb begin
        if (MODE == 0) begin
            w_grant    = bus.sel;
            w_grant_ok = ({1'b0, bus.sel} < NCH_W);
        end else begin
            w_grant    = w_rr_grant;
            w_grant_ok = w_rr_found;
        end
    end

    // Per-channel steering of ready, valid and data for the granted channel.
    // In MODE=0 ready follows load regardless of the channel's own valid.
    always_comb begin
        w_ready       = '0;
        w_grant_valid = 1'b0;
        w_data        = '0;
        for (int i = 0; i < NCH; i++) begin
            if (w_grant == SELW'(i)) begin
                w_ready[i]    = rst_n && w_grant_ok && w_load;
                w_grant_valid = bus.in_valid[i];
                w_data        = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_xfer = w_grant_ok && w_load && w_grant_valid;

    // A new transfer always wins over draining, so out_ready together with a
    // transfer replaces the word without a bubble. The pointer only moves on a
    // transfer, which keeps stalls and idle cycles from skipping a channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_ptr       <= '0;
        end else begin
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_data;
                r_out_ch    <= w_grant;
                if (MODE == 1) begin
                    r_ptr <= (w_grant == LAST_CH) ? '0 : w_grant + 1'b1;
                end
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_ch    = r_out_ch;

endmodule

// File: tb/tb_mux32_arb_rr.sv
// tb/tb_mux32_arb_rr.sv - directed self-checking bench for mux32_arb_rr in both modes

module tb_mux32_arb_rr;
    localparam int WIDTH = 32;
    localparam int NCH   = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mux32_arb_rr_if #(.WIDTH(WIDTH), .NCH(NCH)) if0 ();
    mux32_arb_rr_if #(.WIDTH(WIDTH), .NCH(NCH)) if1 ();

    mux32_arb_rr #(.WIDTH(WIDTH), .NCH(NCH), .MODE(0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0)
    );

    mux32_arb_rr #(.WIDTH(WIDTH), .NCH(NCH), .MODE(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // T1: reset held with every channel valid.
        if0.in_valid  = 3'b111;
        if0.in_data   = {32'h33333333, 32'h22222222, 32'h11111111};
        if0.sel       = 2'd0;
        if0.out_ready = 1'b1;
        if1.in_valid  = 3'b111;
        if1.in_data   = {32'h000000A2, 32'h000000A1, 32'h000000A0};
        if1.sel       = 2'd0;
        if1.out_ready = 1'b1;
        tick();
        tick();
        check("t1_rst_valid0", 32'(if0.out_valid), 32'd0);
        check("t1_rst_data0",  if0.out_data,       32'd0);
        check("t1_rst_ch0",    32'(if0.out_ch),    32'd0);
        check("t1_rst_ready0", 32'(if0.in_ready),  32'd0);
        check("t1_rst_valid1", 32'(if1.out_valid), 32'd0);
        check("t1_rst_ready1", 32'(if1.in_ready),  32'd0);

        rst_n        = 1'b1;
        if1.in_valid = 3'b000;
        #1;
        check("t1_rel_ready0", 32'(if0.in_ready),  32'b001);
        check("t1_rel_ready1", 32'(if1.in_ready),  32'b000);
        check("t1_rel_valid0", 32'(if0.out_valid), 32'd0);
        tick();
        check("t1_first_valid", 32'(if0.out_valid), 32'd1);
        check("t1_first_data",  if0.out_data,       32'h11111111);
        check("t1_first_ch",    32'(if0.out_ch),    32'd0);

        // T2: external select, including an out-of-range sel.
        if0.sel = 2'd2;
        if0.in_data[2*WIDTH +: WIDTH] = 32'hDEADBEEF;
        #1;
        check("t2_ready_sel2", 32'(if0.in_ready), 32'b100);
        tick();
        check("t2_valid", 32'(if0.out_valid), 32'd1);
        check("t2_data",  if0.out_data,       32'hDEADBEEF);
        check("t2_ch",    32'(if0.out_ch),    32'd2);
        if0.sel = 2'd3;
        #1;
        check("t2_ready_sel3", 32'(if0.in_ready), 32'b000);
        tick();
        check("t2_drop_valid", 32'(if0.out_valid), 32'd0);
        check("t2_hold_data",  if0.out_data,       32'hDEADBEEF);
        check("t2_hold_ch",    32'(if0.out_ch),    32'd2);
        // Ready follows load even with the selected channel idle.
        if0.sel      = 2'd1;
        if0.in_valid = 3'b000;
        #1;
        check("t2_ready_novalid", 32'(if0.in_ready), 32'b010);
        tick();
        check("t2_idle_valid", 32'(if0.out_valid), 32'd0);
        if0.sel = 2'd3;

        // T3: round-robin with all channels valid and no backpressure.
        if1.in_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            #1;
            check($sformatf("t3_ready_%0d", k), 32'(if1.in_ready), 32'(1 << (k % 3)));
            tick();
            check($sformatf("t3_ch_%0d", k),    32'(if1.out_ch),    32'(k % 3));
            check($sformatf("t3_valid_%0d", k), 32'(if1.out_valid), 32'd1);
            check($sformatf("t3_data_%0d", k),  if1.out_data,       32'hA0 + 32'(k % 3));
        end

        // T4: backpressure holds the word, release replaces it on the same edge.
        if1.out_ready = 1'b0;
        if1.in_valid  = 3'b010;
        if1.in_data[1*WIDTH +: WIDTH] = 32'h55555555;
        #1;
        check("t4_ready_stall", 32'(if1.in_ready), 32'b000);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("t4_valid_%0d", k), 32'(if1.out_valid), 32'd1);
            check($sformatf("t4_data_%0d", k),  if1.out_data,       32'h000000A2);
            check($sformatf("t4_ready_%0d", k), 32'(if1.in_ready),  32'b000);
        end
        if1.out_ready = 1'b1;
        #1;
        check("t4_ready_release", 32'(if1.in_ready), 32'b010);
        tick();
        check("t4_repl_valid", 32'(if1.out_valid), 32'd1);
        check("t4_repl_data",  if1.out_data,       32'h55555555);
        check("t4_repl_ch",    32'(if1.out_ch),    32'd1);
        if1.in_valid = 3'b000;
        tick();
        check("t4_drain_valid", 32'(if1.out_valid), 32'd0);
        check("t4_idle_ready",  32'(if1.in_ready),  32'b000);

        // T5: sparse valids; pointer sits at 2 after the ch1 grant.
        if1.in_valid = 3'b100;
        #1;
        check("t5_ready_a", 32'(if1.in_ready), 32'b100);
        tick();
        check("t5_ch_a", 32'(if1.out_ch), 32'd2);
        if1.in_valid = 3'b101;
        #1;
        check("t5_ready_b", 32'(if1.in_ready), 32'b001);
        tick();
        check("t5_ch_b", 32'(if1.out_ch), 32'd0);
        check("t5_ready_c", 32'(if1.in_ready), 32'b100);
        tick();
        check("t5_ch_c",   32'(if1.out_ch),    32'd2);
        check("t5_valid_c", 32'(if1.out_valid), 32'd1);

        // T6: asynchronous reset mid-stream, then grant restarts at ch0.
        if1.in_valid = 3'b111;
        tick();
        check("t6_pre_ch0", 32'(if1.out_ch), 32'd0);
        tick();
        check("t6_pre_ch1",    32'(if1.out_ch),    32'd1);
        check("t6_pre_valid",  32'(if1.out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_valid", 32'(if1.out_valid), 32'd0);
        check("t6_async_data",  if1.out_data,       32'd0);
        check("t6_async_ready", 32'(if1.in_ready),  32'b000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("t6_post_ready", 32'(if1.in_ready), 32'b001);
        tick();
        check("t6_post_ch",   32'(if1.out_ch),    32'd0);
        check("t6_post_data", if1.out_data,       32'h000000A0);
        check("t6_post_valid", 32'(if1.out_valid), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
